// File: rtl/rsa_operand_loader.sv
// rtl/rsa_operand_loader.sv - assembles software-written 32-bit words into a wide RSA operand
// Optional input synchronizer: RSA_OPERAND_LOADER_SYNC_EN
module rsa_operand_loader #(
    parameter int WORDS = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [31:0]                  sw_data,
    input  logic [1:0]                   sw_cmd,
    output logic                         hw_ack,
    output logic                         hw_err,
    output logic [$clog2(WORDS+1)-1:0]   word_cnt,
    output logic [32*WORDS-1:0]          op_data,
    output logic                         op_valid,
    input  logic                         op_ready
);

    localparam int OPW = 32 * WORDS;
    localparam int CW  = $clog2(WORDS + 1);

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_START = 2'b10;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACK_WAIT = 2'd1,
        S_PRESENT  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       cmd_smp;
    logic [31:0]      data_smp;
    logic [CW-1:0]    cnt_nxt;
    logic             err_nxt;
    logic [OPW-1:0]   data_nxt;
    logic             full;

`ifdef RSA_OPERAND_LOADER_SYNC_EN
    logic [1:0]  cmd_s1;
    logic [1:0]  cmd_s2;
    logic [31:0] data_s1;
    logic [31:0] data_s2;

    // Two-stage synchronizer on the command, with data delayed equally so both stay aligned
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_s1  <= CMD_IDLE;
            cmd_s2  <= CMD_IDLE;
            data_s1 <= '0;
            data_s2 <= '0;
        end else begin
            cmd_s1  <= sw_cmd;
            cmd_s2  <= cmd_s1;
            data_s1 <= sw_data;
            data_s2 <= data_s1;
        end
    end

    assign cmd_smp  = cmd_s2;
    assign data_smp = data_s2;
`else
    assign cmd_smp  = sw_cmd;
    assign data_smp = sw_data;
`endif

    assign full = (word_cnt == CW'(WORDS));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode of the sampled command
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                case (cmd_smp)
                    CMD_WRITE: state_nxt = S_ACK_WAIT;
                    CMD_START: state_nxt = full ? S_PRESENT : S_ACK_WAIT;
                    CMD_ABORT: state_nxt = S_ACK_WAIT;
                    default:   state_nxt = S_IDLE;
                endcase
            end
            S_ACK_WAIT: begin
                if (cmd_smp == CMD_IDLE) begin
                    state_nxt = S_IDLE;
                end
            end
            S_PRESENT: begin
                // A simultaneous op_ready wins: the transfer completes, the abort is absorbed
                if (op_ready || (cmd_smp == CMD_ABORT)) begin
                    state_nxt = S_ACK_WAIT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values of word count, error flag and operand storage
    always_comb begin
        cnt_nxt  = word_cnt;
        err_nxt  = hw_err;
        data_nxt = op_data;
        case (state)
            S_IDLE: begin
                case (cmd_smp)
                    CMD_WRITE: begin
                        if (full) begin
                            err_nxt = 1'b1;
                        end else begin
                            for (int i = 0; i < WORDS; i++) begin
                                if (word_cnt == CW'(i)) begin
                                    data_nxt[i*32 +: 32] = data_smp;
                                end
                            end
                            cnt_nxt = word_cnt + CW'(1);
                        end
                    end
                    CMD_START: begin
                        if (!full) begin
                            err_nxt = 1'b1;
                        end
                    end
                    CMD_ABORT: begin
                        cnt_nxt = '0;
                        err_nxt = 1'b0;
                    end
                    default: ;
                endcase
            end
            S_PRESENT: begin
                if (op_ready || (cmd_smp == CMD_ABORT)) begin
                    cnt_nxt = '0;
                end
                if (cmd_smp == CMD_ABORT) begin
                    err_nxt = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Output registers; ack and valid are decoded from the next state so they change with it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hw_ack   <= 1'b0;
            hw_err   <= 1'b0;
            word_cnt <= '0;
            op_data  <= '0;
            op_valid <= 1'b0;
        end else begin
            hw_ack   <= (state_nxt == S_ACK_WAIT);
            hw_err   <= err_nxt;
            word_cnt <= cnt_nxt;
            op_data  <= data_nxt;
            op_valid <= (state_nxt == S_PRESENT);
        end
    end

endmodule

// File: tb/tb_rsa_operand_loader.sv
// tb/tb_rsa_operand_loader.sv - directed self-checking bench for rsa_operand_loader
module tb_rsa_operand_loader;

`ifdef RSA_OPERAND_LOADER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [31:0]  sw_data = '0;
    logic [1:0]   sw_cmd = 2'b00;
    logic         hw_ack;
    logic         hw_err;
    logic [2:0]   word_cnt;
    logic [127:0] op_data;
    logic         op_valid;
    logic         op_ready = 1'b0;

    int checks = 0;
    int failures = 0;
    logic saw_valid;

    rsa_operand_loader #(.WORDS(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .sw_data  (sw_data),
        .sw_cmd   (sw_cmd),
        .hw_ack   (hw_ack),
        .hw_err   (hw_err),
        .word_cnt (word_cnt),
        .op_data  (op_data),
        .op_valid (op_valid),
        .op_ready (op_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   cmd;
        logic [31:0]  data;
        logic         ack;
        logic         err;
        logic         valid;
        logic [2:0]   cnt;
        logic [127:0] opd;
    } vec_t;

    vec_t tbl [19];

    localparam logic [127:0] D1 = 128'h00000000_00000000_00000000_11111111;
    localparam logic [127:0] D2 = 128'h00000000_00000000_22222222_11111111;
    localparam logic [127:0] D3 = 128'h00000000_33333333_22222222_11111111;
    localparam logic [127:0] D4 = 128'h44444444_33333333_22222222_11111111;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ack(input logic lvl, input string name, output int n);
        n = 0;
        while (hw_ack !== lvl && n < 20) begin
            step();
            if (op_valid) saw_valid = 1'b1;
            n++;
        end
        if (hw_ack !== lvl) chk({name, "_timeout"}, 128'(hw_ack), 128'(lvl));
    endtask

    task automatic write_word(input logic [31:0] d, output int lat);
        int n;
        sw_data = d;
        sw_cmd  = 2'b01;
        wait_ack(1'b1, "wr_ack", lat);
        sw_cmd  = 2'b00;
        wait_ack(1'b0, "wr_release", n);
    endtask

    task automatic load4(input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3);
        int n;
        write_word(w0, n);
        write_word(w1, n);
        write_word(w2, n);
        write_word(w3, n);
    endtask

    task automatic start_wait_valid(input string name);
        int n;
        op_ready = 1'b0;
        sw_cmd   = 2'b10;
        n = 0;
        while (!op_valid && n < 20) begin
            step();
            n++;
        end
        chk({name, "_valid_up"}, 128'(op_valid), 128'(1'b1));
    endtask

    task automatic transfer(input logic [127:0] exp, input string name);
        int vc;
        int ack_step;
        int n;
        logic [127:0] cap;
        vc = 0;
        ack_step = 0;
        cap = '0;
        op_ready = 1'b1;
        sw_cmd   = 2'b10;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (op_valid) begin
                vc++;
                cap = op_data;
            end
            if (hw_ack) begin
                ack_step = k;
                break;
            end
        end
        chk({name, "_valid_cycles"}, 128'(vc), 128'(1));
        chk({name, "_ack_step"}, 128'(ack_step), 128'(2 + LAT));
        chk({name, "_op_data"}, cap, exp);
        chk({name, "_cnt"}, 128'(word_cnt), 128'(0));
        chk({name, "_valid_low"}, 128'(op_valid), 128'(0));
        sw_cmd   = 2'b00;
        op_ready = 1'b0;
        wait_ack(1'b0, {name, "_release"}, n);
    endtask

    initial begin
        int n;
        int lat;
        int drops;

        tbl[0]  = '{2'b00, 32'h0,        1'b0, 1'b0, 1'b0, 3'd0, 128'h0};
        tbl[1]  = '{2'b01, 32'h11111111, 1'b1, 1'b0, 1'b0, 3'd1, D1};
        tbl[2]  = '{2'b00, 32'h0,        1'b0, 1'b0, 1'b0, 3'd1, D1};
        tbl[3]  = '{2'b10, 32'h0,        1'b1, 1'b1, 1'b0, 3'd1, D1};
        tbl[4]  = '{2'b00, 32'h0,        1'b0, 1'b1, 1'b0, 3'd1, D1};
        tbl[5]  = '{2'b11, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0, D1};
        tbl[6]  = '{2'b00, 32'h0,        1'b0, 1'b0, 1'b0, 3'd0, D1};
        tbl[7]  = '{2'b01, 32'h11111111, 1'b1, 1'b0, 1'b0, 3'd1, D1};
        tbl[8]  = '{2'b00, 32'h11111111, 1'b0, 1'b0, 1'b0, 3'd1, D1};
        tbl[9]  = '{2'b01, 32'h22222222, 1'b1, 1'b0, 1'b0, 3'd2, D2};
        tbl[10] = '{2'b00, 32'h22222222, 1'b0, 1'b0, 1'b0, 3'd2, D2};
        tbl[11] = '{2'b01, 32'h33333333, 1'b1, 1'b0, 1'b0, 3'd3, D3};
        tbl[12] = '{2'b00, 32'h33333333, 1'b0, 1'b0, 1'b0, 3'd3, D3};
        tbl[13] = '{2'b01, 32'h44444444, 1'b1, 1'b0, 1'b0, 3'd4, D4};
        tbl[14] = '{2'b00, 32'h44444444, 1'b0, 1'b0, 1'b0, 3'd4, D4};
        tbl[15] = '{2'b01, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 3'd4, D4};
        tbl[16] = '{2'b00, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 3'd4, D4};
        tbl[17] = '{2'b11, 32'h0,        1'b1, 1'b0, 1'b0, 3'd0, D4};
        tbl[18] = '{2'b00, 32'h0,        1'b0, 1'b0, 1'b0, 3'd0, D4};

        saw_valid = 1'b0;
        step();
        chk("reset_ack", 128'(hw_ack), 128'(0));
        chk("reset_err", 128'(hw_err), 128'(0));
        chk("reset_valid", 128'(op_valid), 128'(0));
        chk("reset_cnt", 128'(word_cnt), 128'(0));
        chk("reset_data", op_data, 128'h0);
        reset_n = 1'b1;
        step();

        // Table: each row held until its response has had time to appear
        for (int i = 0; i < 19; i++) begin
            sw_cmd  = tbl[i].cmd;
            sw_data = tbl[i].data;
            repeat (1 + LAT) step();
            chk($sformatf("row%0d_ack", i), 128'(hw_ack), 128'(tbl[i].ack));
            chk($sformatf("row%0d_err", i), 128'(hw_err), 128'(tbl[i].err));
            chk($sformatf("row%0d_valid", i), 128'(op_valid), 128'(tbl[i].valid));
            chk($sformatf("row%0d_cnt", i), 128'(word_cnt), 128'(tbl[i].cnt));
            chk($sformatf("row%0d_data", i), op_data, tbl[i].opd);
        end

        // Full load and transfer with op_ready held high in advance
        write_word(32'hC0C0C0C0, lat);
        chk("write_ack_latency", 128'(lat), 128'(1 + LAT));
        write_word(32'hC1C1C1C1, lat);
        write_word(32'hC2C2C2C2, lat);
        write_word(32'hC3C3C3C3, lat);
        transfer(128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0, "xfer1");

        // Underflow after two words: error, ack, no valid, words kept
        write_word(32'h55555555, lat);
        write_word(32'h66666666, lat);
        saw_valid = 1'b0;
        sw_cmd = 2'b10;
        wait_ack(1'b1, "under_ack", n);
        chk("under_err", 128'(hw_err), 128'(1));
        chk("under_cnt", 128'(word_cnt), 128'(2));
        chk("under_no_valid", 128'(saw_valid), 128'(0));
        sw_cmd = 2'b00;
        wait_ack(1'b0, "under_release", n);

        // Complete the load with err still set, then stall in PRESENT and abort
        write_word(32'h77777777, lat);
        write_word(32'h88888888, lat);
        start_wait_valid("stall");
        chk("stall_err_kept", 128'(hw_err), 128'(1));
        chk("stall_data", op_data, 128'h88888888_77777777_66666666_55555555);
        drops = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (!op_valid || hw_ack) drops++;
        end
        chk("stall_held", 128'(drops), 128'(0));
        sw_cmd = 2'b11;
        wait_ack(1'b1, "abort_ack", n);
        chk("abort_valid", 128'(op_valid), 128'(0));
        chk("abort_cnt", 128'(word_cnt), 128'(0));
        chk("abort_err", 128'(hw_err), 128'(0));
        chk("abort_data_kept", op_data, 128'h88888888_77777777_66666666_55555555);
        sw_cmd = 2'b00;
        wait_ack(1'b0, "abort_release", n);

        // op_ready and abort arriving together still complete the transfer
        load4(32'h1, 32'h2, 32'h3, 32'h4);
        start_wait_valid("both");
        op_ready = 1'b1;
        sw_cmd   = 2'b11;
        wait_ack(1'b1, "both_ack", n);
        chk("both_valid", 128'(op_valid), 128'(0));
        chk("both_cnt", 128'(word_cnt), 128'(0));
        chk("both_err", 128'(hw_err), 128'(0));
        op_ready = 1'b0;
        sw_cmd   = 2'b00;
        wait_ack(1'b0, "both_release", n);

        // Asynchronous reset while presenting
        load4(32'h9, 32'hA, 32'hB, 32'hC);
        start_wait_valid("rst");
        sw_cmd  = 2'b00;
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_valid", 128'(op_valid), 128'(0));
        chk("rst_ack", 128'(hw_ack), 128'(0));
        chk("rst_err", 128'(hw_err), 128'(0));
        chk("rst_cnt", 128'(word_cnt), 128'(0));
        chk("rst_data", op_data, 128'h0);
        step();
        reset_n = 1'b1;
        step();
        chk("rst_idle_ack", 128'(hw_ack), 128'(0));
        load4(32'hF0000000, 32'hF1111111, 32'hF2222222, 32'hF3333333);
        transfer(128'hF3333333_F2222222_F1111111_F0000000, "xfer2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
